// File: rtl/rr_arb_4x1_if.sv
// rtl/rr_arb_4x1_if.sv - requester/output handshake bundle for rr_arb_4x1
// Signals:
//   req_valid[3:0]        per-requester valid
//   req_data0..req_data3  per-requester payloads
//   req_ready[3:0]        per-requester ready, one-hot or zero
//   out_valid/out_data    registered output beat
//   out_sel[1:0]          index of the requester that supplied out_data
//   out_ready             downstream accepts the beat
// Modports: slave = arbiter side, master = requesters plus downstream side.
interface rr_arb_4x1_if #(
   parameter int DATA_W = 8
);
   logic [3:0]        req_valid;
   logic [DATA_W-1:0] req_data0;
   logic [DATA_W-1:0] req_data1;
   logic [DATA_W-1:0] req_data2;
   logic [DATA_W-1:0] req_data3;
   logic [3:0]        req_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_sel;
   logic              out_ready;

   modport slave (
      input  req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
      output req_ready, out_valid, out_data, out_sel
   );

   modport master (
      output req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
      input  req_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb_4x1.sv
// rtl/rr_arb_4x1.sv - four-requester byte arbiter with a single registered output stage
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_prio_mode  0 = round-robin, 1 = fixed priority (requester 0 highest)
//   bus          rr_arb_4x1_if.slave handshake bundle (requesters in, output beat out)
//   o_xfer_cnt   count of accepted requester beats, wraps
module rr_arb_4x1 #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_prio_mode,
   rr_arb_4x1_if.slave      bus,
   output logic [CNT_W-1:0] o_xfer_cnt
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [1:0]        r_out_sel;
   logic [1:0]        r_last_gnt;
   logic [CNT_W-1:0]  r_xfer_cnt;

   logic              w_load_en;
   logic              w_any;
   logic              w_found;
   logic [1:0]        w_idx;
   logic [1:0]        w_gnt;
   logic [3:0]        w_req_ready;
   logic              w_accept;
   logic [DATA_W-1:0] w_gnt_data;

   // The output stage can take a beat when empty or when draining this cycle.
   assign w_load_en = !r_out_valid | bus.out_ready;
   assign w_any     = |bus.req_valid;

   // Search order: round-robin starts one past the last winner, fixed starts at 0.
   always_comb begin
      w_gnt   = 2'd0;
      w_found = 1'b0;
      w_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (i_prio_mode)
            w_idx = 2'(k);
         else
            w_idx = r_last_gnt + 2'(k) + 2'd1;
         if (!w_found && bus.req_valid[w_idx]) begin
            w_gnt   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_req_ready = 4'b0000;
      if (w_load_en && w_any && !i_rst)
         w_req_ready[w_gnt] = 1'b1;
   end

   assign w_accept = |(bus.req_valid & w_req_ready);

   always_comb begin
      case (w_gnt)
         2'd0:    w_gnt_data = bus.req_data0;
         2'd1:    w_gnt_data = bus.req_data1;
         2'd2:    w_gnt_data = bus.req_data2;
         default: w_gnt_data = bus.req_data3;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= 2'd0;
         r_last_gnt  <= 2'd3;   // requester 0 is searched first after reset
         r_xfer_cnt  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_gnt_data;
         r_out_sel   <= w_gnt;
         r_last_gnt  <= w_gnt;
         r_xfer_cnt  <= r_xfer_cnt + 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
         // Drained with nothing to replace it; data and select keep stale values.
         r_out_valid <= 1'b0;
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;
   assign o_xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_rr_arb_4x1.sv
// tb/tb_rr_arb_4x1.sv - table-driven testbench for rr_arb_4x1
module tb_rr_arb_4x1;

   logic        clk;
   logic        rst;
   logic        prio_mode;
   logic [15:0] xfer_cnt;

   int checks;
   int failures;

   rr_arb_4x1_if #(.DATA_W(8)) bus ();

   rr_arb_4x1 #(.DATA_W(8), .CNT_W(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_prio_mode (prio_mode),
      .bus         (bus),
      .o_xfer_cnt  (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        prio;
      logic [3:0]  valid;
      logic        ready;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [1:0]  exp_sel;
      logic [7:0]  exp_data;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic ov, input logic [1:0] sel,
                            input logic [7:0] data, input logic [15:0] cnt);
      chk({tag, "_ov"},   {31'd0, bus.out_valid}, {31'd0, ov});
      chk({tag, "_sel"},  {30'd0, bus.out_sel},   {30'd0, sel});
      chk({tag, "_data"}, {24'd0, bus.out_data},  {24'd0, data});
      chk({tag, "_cnt"},  {16'd0, xfer_cnt},      {16'd0, cnt});
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      prio_mode = 1'b0;
      bus.req_valid = 4'hF;
      bus.out_ready = 1'b1;
      bus.req_data0 = 8'h10;
      bus.req_data1 = 8'h11;
      bus.req_data2 = 8'h12;
      bus.req_data3 = 8'h13;

      //            rst   prio  valid    rdy  | rdy      ov    sel   data    cnt
      // reset held 3 cycles with all valid
      vecs[0]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0};
      vecs[1]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0};
      vecs[2]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0};
      // round-robin fairness
      vecs[3]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd1};
      vecs[4]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd2};
      vecs[5]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd3};
      vecs[6]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd4};
      vecs[7]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd5};
      // skip idle requesters 0 and 2
      vecs[8]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd6};
      vecs[9]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd7};
      vecs[10] = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd8};
      vecs[11] = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd9};
      // backpressure after a beat from requester 0
      vecs[12] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd10};
      vecs[13] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10, 16'd10};
      vecs[14] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10, 16'd10};
      vecs[15] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10, 16'd10};
      vecs[16] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10, 16'd10};
      vecs[17] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd11};
      // fixed priority, then drop requester 0, then back to round-robin
      vecs[18] = '{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd12};
      vecs[19] = '{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd13};
      vecs[20] = '{1'b0, 1'b1, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd14};
      vecs[21] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd15};
      // nothing valid: drain, then stay empty with stale data/sel
      vecs[22] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h12, 16'd15};
      vecs[23] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h12, 16'd15};
      // single requester wins every cycle regardless of pointer
      vecs[24] = '{1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd16};
      vecs[25] = '{1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd17};

      #1;
      for (int i = 0; i < 26; i++) begin
         rst           = vecs[i].rst;
         prio_mode     = vecs[i].prio;
         bus.req_valid = vecs[i].valid;
         bus.out_ready = vecs[i].ready;
         #1;
         chk($sformatf("v%0d_rdy", i), {28'd0, bus.req_ready}, {28'd0, vecs[i].exp_rdy});
         tick();
         check_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_sel,
                   vecs[i].exp_data, vecs[i].exp_cnt);
      end

      // Counter wrap: accept beats until the counter reaches 0xFFFE, then two more.
      rst           = 1'b0;
      prio_mode     = 1'b0;
      bus.req_valid = 4'hF;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 16'hFFFE - 17; n++) begin
         @(posedge clk);
      end
      #1;
      chk("wrap_pre", {16'd0, xfer_cnt}, 32'h0000_FFFE);
      tick();
      chk("wrap_ffff", {16'd0, xfer_cnt}, 32'h0000_FFFF);
      tick();
      chk("wrap_zero", {16'd0, xfer_cnt}, 32'h0000_0000);
      chk("wrap_ov", {31'd0, bus.out_valid}, 32'd1);

      // Reset mid-burst: pending beat discarded, nothing accepted.
      rst = 1'b1;
      #1;
      chk("midrst_rdy", {28'd0, bus.req_ready}, 32'd0);
      tick();
      check_out("midrst", 1'b0, 2'd0, 8'h00, 16'd0);

      // First cycle after release grants requester 0.
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", {28'd0, bus.req_ready}, 32'b0001);
      tick();
      check_out("post_rst", 1'b1, 2'd0, 8'h10, 16'd1);
      // Simultaneous drain and accept keeps out_valid high with the next beat.
      tick();
      check_out("no_bubble", 1'b1, 2'd1, 8'h11, 16'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arb_4x1.md
# rr_arb_4x1

Four-requester byte arbiter that shares a single 8-bit output channel between four valid/ready sources. It selects one requester per cycle (round-robin or fixed priority) and registers the selected byte with its source index into a single output stage. Each output beat carries the driving select code. It sits in front of the RAM write-data path, wherever several byte producers contend for one port.

## Interface
- DATA_W, 8, width of each requester's data and the output data
- CNT_W, 16, width of the accepted-beat counter
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (req 0 highest, req 3 lowest)
- req_valid  in  4  per-requester valid, bit i = requester i
- req_data0..req_data3  in  DATA_W each  requester payloads
- req_ready  out  4  per-requester ready, at most one bit high
- out_valid  out  1  output register holds a beat
- out_data  out  DATA_W  selected payload
- out_sel  out  2  index of the requester that supplied out_data (mux select code)
- out_ready  in  1  downstream accepts the beat
- xfer_cnt  out  CNT_W  count of accepted requester beats, wraps modulo 2^CNT_W

## Operation
- State: output register (out_valid, out_data, out_sel), priority pointer last_gnt[1:0], counter xfer_cnt.
- load_en = !out_valid | out_ready. The output stage can take a new beat when it is empty or when it is draining this cycle.
- Grant (combinational):
  - Round-robin: search order is last_gnt+1, +2, +3, +4 (mod 4). The first index with req_valid set wins.
  - Fixed: lowest index with req_valid set wins.
- req_ready[g] = load_en & |req_valid & !rst, and only for the granted g. All other bits are 0. req_ready depends combinationally on out_ready and req_valid.
- Accept happens when req_valid[g] & req_ready[g]. On accept:
  - out_data <= req_data[g], out_sel <= g, out_valid <= 1.
  - last_gnt <= g.
  - xfer_cnt <= xfer_cnt + 1, wrapping from 0xFFFF to 0.
- out_valid & out_ready with no accept: out_valid <= 0. out_data and out_sel hold their stale values.
- Backpressure (out_valid & !out_ready): out_valid, out_data and out_sel hold stable. req_ready = 0. last_gnt does not move.
- last_gnt updates only on accept; it never moves in idle cycles. In fixed mode last_gnt is still updated, so switching back to round-robin resumes after the last winner.
- prio_mode may change on any cycle. It takes effect for the grant in that same cycle.
- Requesters must hold req_valid and req_data until accepted (AXI-style). The block does not check this.

## Timing
- Reset values (clocked, sync): out_valid=0, out_data=0, out_sel=0, last_gnt=3 (so requester 0 is first in round-robin), xfer_cnt=0. req_ready=0 while rst=1.
- Latency: accept in cycle N gives out_valid=1 with the data in cycle N+1.
- Throughput: one beat per cycle when out_ready is held high and any requester is valid.
- Simultaneous drain and accept in the same cycle: the register reloads with the new beat and out_valid stays 1. There is no bubble.
- No valid requesters while load_en=1: no grant, req_ready=0, and out_valid drops if it was draining.
- Reset asserted mid-burst: the pending output beat is discarded and nothing is accepted in that cycle. Arbitration restarts from requester 0 on the first cycle after rst deasserts.
- Single requester valid: it wins every cycle regardless of the pointer.

## Test plan
- Reset check: hold rst for 3 cycles with all req_valid=4'hF. Required: req_ready=0, out_valid=0, out_data=0, out_sel=0, xfer_cnt=0. After release, the first grant is requester 0.
- Round-robin fairness: data 8'h10/11/12/13 on requesters 0-3, all valid, out_ready=1, prio_mode=0. Required: out_sel 0,1,2,3,0 and out_data 10,11,12,13,10 on consecutive cycles, one beat per cycle, xfer_cnt increments each cycle.
- Skip idle requesters: req_valid=4'b1010, round-robin. Required: out_sel alternates 1,3,1,3 and req_ready never asserts for 0 or 2.
- Backpressure: out_ready=0 for 4 cycles after the first beat (out_sel=0, out_data=8'h10). Required: output holds 8'h10/sel 0, req_ready=4'b0000, xfer_cnt frozen. After out_ready=1, the next beat is requester 1 with 8'h11.
- Fixed priority: prio_mode=1, all valid, out_ready=1. Required: out_sel=0 every cycle. Then drop req_valid[0]: out_sel=1. Switch back to round-robin: the next grant follows the last winner.
- Counter wrap and reset mid-burst: preload 0xFFFE beats (or force the counter), accept 2 beats, and check xfer_cnt=0. Then assert rst while out_valid=1 and check out_valid=0 on the next edge.
